inst_loader: RTL and testbench

- Writer side of the instruction BRAM. It takes a program as a byte stream from the UART receiver and assembles big-endian 32-bit words.
- Each word is written sequentially into INST_BRAM through port A (addra/dina/wea), starting at address 0.
- Loading stops after the halt sentinel word has been written. The instruction fetch stage later reads the same image back.

---
 rtl/inst_loader.sv | 184 ++++++++++++++++++
 tb/tb_inst_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: writer side of the instruction BRAM.
// Assembles big-endian 32-bit words from a UART byte stream and writes them
// sequentially into BRAM port A from address 0. Loading ends after the
// sentinel word has been written, or when the last address has been filled
// (overflow).
// Optional feature: define INST_LOADER_CHECKSUM_EN to build a running
// mod-2**32 sum of all written words on the checksum output. When the macro
// is undefined, checksum is tied to zero and no adder exists.
module inst_loader #(
  parameter int          INST_SIZE = 10,
  parameter logic [31:0] SENTINEL  = 32'h0000_003F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [INST_SIZE-1:0] addra,
  output logic [31:0]          dina,
  output logic                 wea,
  output logic                 done,
  output logic                 overflow,
  output logic [INST_SIZE:0]   word_count,
  output logic [31:0]          checksum
);

  // WRITE drives the write strobe; CHECK is the cycle after it, where the
  // strobe drops and the end-of-load decision is made.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [INST_SIZE-1:0] LAST_ADDR = '1;
  localparam logic [INST_SIZE-1:0] ADDR_ONE  = {{(INST_SIZE-1){1'b0}}, 1'b1};
  localparam logic [INST_SIZE:0]   CNT_ONE   = {{INST_SIZE{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [INST_SIZE-1:0] addra_q, addra_d;
  logic [31:0]          dina_q, dina_d;
  logic                 wea_q, wea_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [INST_SIZE:0]   word_count_q, word_count_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [31:0]          shift_q, shift_d;
  logic                 byte_accept;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]          checksum_q, checksum_d;
`endif

  // Bytes are taken while a load is in progress, including the WRITE/CHECK
  // cycles, so a fast sender never loses the first bytes of the next word.
  assign byte_accept = rx_valid &&
                       ((state_q == S_RECV) || (state_q == S_WRITE) ||
                        (state_q == S_CHECK));

  // Next-state and next-output computation for the whole loader.
  always_comb begin
    state_d      = state_q;
    addra_d      = addra_q;
    dina_d       = dina_q;
    wea_d        = 1'b0;
    done_d       = done_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
`ifdef INST_LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    if (byte_accept) begin
      shift_d    = {shift_q[23:0], rx_data};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RECV;
          addra_d      = '0;
          byte_cnt_d   = '0;
          shift_d      = '0;
          word_count_d = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end

      S_RECV: begin
        // Fourth byte completes the word; first byte sits in [31:24].
        if (rx_valid && (byte_cnt_q == 2'd3)) begin
          dina_d     = {shift_q[23:0], rx_data};
          byte_cnt_d = '0;
          state_d    = S_WRITE;
        end
      end

      S_WRITE: begin
        wea_d        = 1'b1;
        word_count_d = word_count_q + CNT_ONE;
`ifdef INST_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q + dina_q;
`endif
        state_d      = S_CHECK;
      end

      S_CHECK: begin
        if (dina_q == SENTINEL) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (addra_q == LAST_ADDR) begin
          // Address space exhausted without a sentinel; never wrap.
          done_d     = 1'b1;
          overflow_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          addra_d = addra_q + ADDR_ONE;
          state_d = S_RECV;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any load immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addra_q      <= '0;
      dina_q       <= '0;
      wea_q        <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
    end else begin
      state_q      <= state_d;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
      wea_q        <= wea_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  // Running sum of every word written in the current load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

  assign addra      = addra_q;
  assign dina       = dina_q;
  assign wea        = wea_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader (built with INST_SIZE=2 so overflow is reachable).
// Stimulus pushes expected BRAM writes into a scoreboard queue; a monitor on
// the falling clock edge pops and compares every wea pulse.
module tb_inst_loader;

  localparam int          ISZ   = 2;
  localparam int          DEPTH = 1 << ISZ;
  localparam logic [31:0] SENT  = 32'h0000_003F;

  logic             clk;
  logic             rst;
  logic             start;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [ISZ-1:0]   addra;
  logic [31:0]      dina;
  logic             wea;
  logic             done;
  logic             overflow;
  logic [ISZ:0]     word_count;
  logic [31:0]      checksum;

  inst_loader #(.INST_SIZE(ISZ), .SENTINEL(SENT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .addra      (addra),
    .dina       (dina),
    .wea        (wea),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ISZ-1:0] addr;
    logic [31:0]    data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] stim_words[$];
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] exp_img [0:DEPTH-1];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst && wea) begin
      mem[addra] <= dina;
      $display("write addr=%0d data=%08h", addra, dina);
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h expected no write", addra, dina);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(addra), 64'(e.addr));
        check("wr_data", 64'(dina), 64'(e.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++)
      send_byte(w[31-8*k -: 8], $urandom_range(0, max_gap));
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = a[ISZ-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) cyc();
    check("done", 64'(done), 64'd1);
  endtask

  function automatic logic [31:0] exp_ck(input logic [31:0] sum);
`ifdef INST_LOADER_CHECKSUM_EN
    return sum;
`else
    return 32'h0 & sum;
`endif
  endfunction

  // Reference model: words are written in order until the sentinel has been
  // written or the BRAM is full; later bytes are ignored.
  task automatic run_load(input int max_gap);
    int          n;
    logic [31:0] sum;
    logic        ovf;
    logic        term;
    n = 0; sum = 0; ovf = 0; term = 0;
    foreach (stim_words[i]) begin
      if (!term) begin
        push_exp(n, stim_words[i]);
        exp_img[n] = stim_words[i];
        sum += stim_words[i];
        n++;
        if (stim_words[i] == SENT) term = 1;
        else if (n == DEPTH) begin term = 1; ovf = 1; end
      end
    end
    pulse_start();
    foreach (stim_words[i]) send_word(stim_words[i], max_gap);
    wait_done(400);
    repeat (3) cyc();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("overflow", 64'(overflow), 64'(ovf));
    check("word_count", 64'(word_count), 64'(n));
    check("checksum", 64'(checksum), 64'(exp_ck(sum)));
    for (int k = 0; k < n; k++) check("readback", 64'(mem[k]), 64'(exp_img[k]));
  endtask

  initial begin
    logic [31:0] w;
    int          n;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addra", 64'(addra), 64'd0);
    check("rst_dina", 64'(dina), 64'd0);
    check("rst_wea", 64'(wea), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    rst = 1'b0;
    cyc();

    // rx_valid in IDLE is ignored
    send_word(32'hCAFE_F00D, 0);
    repeat (4) cyc();
    check("idle_no_wc", 64'(word_count), 64'd0);

    // Basic load with latency checks on the sentinel word
    pulse_start();
    push_exp(0, 32'h1234_5678);
    push_exp(1, 32'hDEAD_BEEF);
    push_exp(2, SENT);
    send_word(32'h1234_5678, 2);
    send_word(32'hDEAD_BEEF, 2);
    send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    send_byte(8'h3F, 0);
    check("lat_wea_n", 64'(wea), 64'd0);
    cyc();
    check("lat_wea_n1", 64'(wea), 64'd1);
    check("lat_done_n1", 64'(done), 64'd0);
    cyc();
    check("lat_wea_n2", 64'(wea), 64'd0);
    check("lat_done_n2", 64'(done), 64'd1);
    check("basic_overflow", 64'(overflow), 64'd0);
    check("basic_word_count", 64'(word_count), 64'd3);
    check("basic_checksum", 64'(checksum),
          64'(exp_ck(32'h1234_5678 + 32'hDEAD_BEEF + SENT)));

    // Back-to-back bytes, including a byte in the WRITE cycle
    stim_words.delete();
    stim_words.push_back(32'hA1B2_C3D4);
    stim_words.push_back(32'h0102_0304);
    stim_words.push_back(SENT);
    run_load(0);

    // Overflow: fill every address without a sentinel, then a 5th word
    stim_words.delete();
    for (int i = 0; i < DEPTH; i++) stim_words.push_back($urandom | 32'h100);
    run_load(1);
    check("ovf_done", 64'(done), 64'd1);
    send_word(32'h5555_AAAA, 1);
    repeat (5) cyc();
    check("ovf_hold_addra", 64'(addra), 64'(DEPTH - 1));
    check("ovf_hold_wc", 64'(word_count), 64'(DEPTH));
    check("ovf_hold_flag", 64'(overflow), 64'd1);

    // start during RECV is ignored
    pulse_start();
    push_exp(0, 32'h89AB_CDEF);
    push_exp(1, SENT);
    send_byte(8'h89, 1); send_byte(8'hAB, 1);
    pulse_start();
    send_byte(8'hCD, 1); send_byte(8'hEF, 1);
    send_word(SENT, 1);
    wait_done(200);
    check("midstart_wc", 64'(word_count), 64'd2);
    check("midstart_addra", 64'(addra), 64'd1);

    // Async reset between clock edges in the middle of a word
    pulse_start();
    push_exp(0, 32'h7766_5544);
    send_word(32'h7766_5544, 1);
    repeat (3) cyc();
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    #3 rst = 1'b1;
    #1;
    check("arst_addra", 64'(addra), 64'd0);
    check("arst_dina", 64'(dina), 64'd0);
    check("arst_wc", 64'(word_count), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_checksum", 64'(checksum), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    cyc();
    pulse_start();
    push_exp(0, SENT);
    send_word(SENT, 1);
    wait_done(200);
    check("arst_new_addra", 64'(addra), 64'd0);
    check("arst_new_wc", 64'(word_count), 64'd1);

    // Restart from DONE
    pulse_start();
    check("restart_done", 64'(done), 64'd0);
    check("restart_wc", 64'(word_count), 64'd0);
    push_exp(0, 32'h0BAD_F00D);
    push_exp(1, SENT);
    send_word(32'h0BAD_F00D, 2);
    send_word(SENT, 2);
    wait_done(200);
    check("restart_wc_end", 64'(word_count), 64'd2);

    // Randomized loads against the reference model
    for (int t = 0; t < 8; t++) begin
      stim_words.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        w = $urandom | 32'h100;
        stim_words.push_back(w);
      end
      if (n < DEPTH || $urandom_range(0, 1) == 1) stim_words[n-1] = SENT;
      run_load($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
